// File: rtl/fuel_pump_ctrl.sv
// Multi-pump fuel immobiliser controller.
// The pumps are enabled only after ignition, the hidden switch and the brake
// have been held high together long enough to arm. Once armed, the pumps start
// one after another to limit inrush current. Repeated failed arming attempts
// put the controller into a timed lockout, and the alarm core can force a
// shutdown at any time outside lockout.
// Optional feature: define FUEL_PUMP_PRIME_EN to run pump 0 for a short prime
// pulse after key-on while the controller is still idle.
module fuel_pump_ctrl #(
    parameter int NUM_PUMPS      = 2,
    parameter int ARM_CYCLES     = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int PRIME_CYCLES   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ignition_i,
    input  logic                 switch_i,
    input  logic                 brake_i,
    input  logic                 alarm_i,
    output logic [NUM_PUMPS-1:0] status_o,
    output logic                 running_o,
    output logic                 locked_o
);

    // Each counter is sized for the largest value it ever has to hold.
    localparam int RUN_MAX = (NUM_PUMPS - 1) * STAGGER_CYCLES;
    localparam int AW = (ARM_CYCLES > 2) ? $clog2(ARM_CYCLES - 1) : 1;
    localparam int RW = (RUN_MAX > 0) ? $clog2(RUN_MAX + 1) : 1;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    // The edge that leaves IDLE is the first of the ARM_CYCLES go edges.
    // arm_cnt therefore counts the go edges seen while in ARMING, and RUN is
    // taken on the edge where arm_cnt has reached ARM_CYCLES-2.
    localparam logic [AW-1:0] ARM_LAST  = AW'((ARM_CYCLES > 1) ? ARM_CYCLES - 2 : 0);
    localparam logic [RW-1:0] RUN_SAT   = RW'(RUN_MAX);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_TRIES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_RUN     = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   arm_cnt_q, arm_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            go;
    logic            prime_active;

    assign go = ignition_i & switch_i & brake_i;

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            arm_cnt_q  <= '0;
            run_cnt_q  <= '0;
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            run_cnt_q  <= run_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state and counter update; alarm outranks the state rules except in LOCKOUT.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        run_cnt_d  = run_cnt_q;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go && !alarm_i) begin
                    if (ARM_CYCLES == 1) begin
                        state_d    = ST_RUN;
                        run_cnt_d  = '0;
                        fail_cnt_d = '0;
                    end else begin
                        state_d   = ST_ARMING;
                        arm_cnt_d = '0;
                    end
                end
            end
            ST_ARMING: begin
                if (alarm_i) begin
                    state_d = ST_IDLE;
                end else if (!go) begin
                    // One failure per aborted attempt; the counter saturates.
                    if (fail_cnt_q >= FAIL_MAX - FW'(1)) begin
                        fail_cnt_d = FAIL_MAX;
                        state_d    = ST_LOCKOUT;
                        lock_cnt_d = '0;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FW'(1);
                        state_d    = ST_IDLE;
                    end
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d    = ST_RUN;
                    run_cnt_d  = '0;
                    fail_cnt_d = '0;
                end else if (arm_cnt_q != {AW{1'b1}}) begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (!ignition_i || alarm_i) begin
                    state_d = ST_IDLE;
                end else if (run_cnt_q < RUN_SAT) begin
                    run_cnt_d = run_cnt_q + RW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FUEL_PUMP_PRIME_EN
    localparam int PW = $clog2(PRIME_CYCLES + 1);

    logic          ign_q;
    logic [PW-1:0] prime_cnt_q, prime_cnt_d;

    // Prime counter: loaded on key-on in IDLE, cancelled by alarm, key-off or leaving IDLE.
    always_comb begin
        prime_cnt_d = prime_cnt_q;
        if (state_q != ST_IDLE || state_d != ST_IDLE || alarm_i || !ignition_i) begin
            prime_cnt_d = '0;
        end else if (!ign_q) begin
            prime_cnt_d = PW'(PRIME_CYCLES);
        end else if (prime_cnt_q != '0) begin
            prime_cnt_d = prime_cnt_q - PW'(1);
        end
    end

    // Key-on edge detector and prime counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ign_q       <= 1'b0;
            prime_cnt_q <= '0;
        end else begin
            ign_q       <= ignition_i;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    assign prime_active = (state_q == ST_IDLE) && (prime_cnt_q != '0);
`else
    assign prime_active = 1'b0;
`endif

    // Outputs decoded purely from registered state.
    always_comb begin
        running_o = (state_q == ST_RUN);
        locked_o  = (state_q == ST_LOCKOUT);
        for (int k = 0; k < NUM_PUMPS; k++) begin
            status_o[k] = (state_q == ST_RUN) && (run_cnt_q >= RW'(k * STAGGER_CYCLES));
        end
        if (prime_active) begin
            status_o[0] = 1'b1;
        end
    end

endmodule
